// File: rtl/dbus_responder.sv
// Data-bus responder: word RAM plus MMIO block (VERIFY, DONE, CYCLE, ERR). Reads are
// combinational; writes commit at the clock edge. No backpressure: one access per cycle.
module dbus_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [31:0] verify,
    output logic        done,
    output logic [31:0] cycle_cnt,
    output logic        err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem [DEPTH_WORDS];
    logic          misaligned;
    logic          hit_ram;
    logic          hit_mmio;
    logic          bad;
    logic          wr;
    logic          done_set;
    logic          err_clr;
    logic          verify_wr;
    logic [AW-1:0] ram_idx;
    logic [1:0]    reg_sel;

    // Decode order matters: alignment first, then RAM, then the MMIO window.
    always_comb begin
        misaligned = addr[1:0] != 2'b00;
        hit_ram    = !misaligned && (addr < RAM_BYTES);
        hit_mmio   = !misaligned && !hit_ram && (addr[31:4] == MMIO_BASE[31:4]);
        bad        = ce && !hit_ram && !hit_mmio;
        ram_idx    = addr[AW+1:2];
        reg_sel    = addr[3:2];
        wr         = ce && we;
        verify_wr  = wr && hit_mmio && (reg_sel == 2'd0);
        done_set   = wr && hit_mmio && (reg_sel == 2'd1) && (data_i != 32'h0);
        err_clr    = wr && hit_mmio && (reg_sel == 2'd3) && data_i[0];
    end

    always_comb begin
        data_o = 32'h0;
        if (ce && !we) begin
            if (hit_ram) begin
                data_o = mem[ram_idx];
            end else if (hit_mmio) begin
                case (reg_sel)
                    2'd0:    data_o = verify;
                    2'd1:    data_o = {31'b0, done};
                    2'd2:    data_o = cycle_cnt;
                    default: data_o = {31'b0, err};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            verify    <= 32'h0;
            done      <= 1'b0;
            cycle_cnt <= 32'h0;
            err       <= 1'b0;
        end else begin
            // The edge that raises done does not count, so the count freezes at its pre-done value.
            if (!done && !done_set && (cycle_cnt != 32'hFFFF_FFFF)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (done_set) begin
                done <= 1'b1;
            end
            if (verify_wr) begin
                verify <= data_i;
            end
            if (err_clr) begin
                err <= 1'b0;
            end
            if (bad) begin
                err <= 1'b1;
            end
        end
    end

    // RAM is deliberately not reset; writes in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (rst && wr && hit_ram) begin
            mem[ram_idx] <= data_i;
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized + directed bench for dbus_responder with a queue-based scoreboard.
module tb_dbus_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] MB    = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst, ce, we;
    logic [31:0] addr, data_i;
    logic [31:0] data_o, verify, cycle_cnt;
    logic        done, err;

    dbus_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .data_i(data_i),
        .data_o(data_o), .verify(verify), .done(done), .cycle_cnt(cycle_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc_now = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    // Reference model: plain architectural state, RAM keyed by word index.
    logic [31:0] m_mem [int];
    logic [31:0] m_verify, m_cnt;
    bit          m_done, m_err, m_valid;

    function automatic int region(input logic [31:0] a);
        if (a % 4 != 0)                 return 2;
        if (a < DEPTH * 4)              return 0;
        if (a >= MB && (a - MB) < 16)   return 1;
        return 2;
    endfunction

    task automatic push(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc_now; e.sel = sel; e.exp = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic model_step(input bit r, input bit c, input bit w,
                              input logic [31:0] a, input logic [31:0] d);
        int  rg;
        bit  sets_done;
        if (!r) begin
            m_verify = 0; m_cnt = 0; m_done = 0; m_err = 0; m_valid = 1;
            return;
        end
        rg = region(a);
        sets_done = c && w && rg == 1 && (a - MB) == 4 && d != 0;
        if (!m_done && !sets_done && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (c) begin
            if (rg == 2) m_err = 1;
            else if (w) begin
                if (rg == 0) m_mem[int'(a / 4)] = d;
                else case (a - MB)
                    0:  m_verify = d;
                    4:  if (d != 0) m_done = 1;
                    12: if (d[0]) m_err = 0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
        int          rg;
        bit          known;
        logic [31:0] ev;
        @(posedge clk);
        #1;
        rst = r; ce = c; we = w; addr = a; data_i = d;
        cyc_now++;
        if (m_valid) begin
            push(1, m_verify, "verify");
            push(2, {31'b0, m_done}, "done");
            push(3, m_cnt, "cycle_cnt");
            push(4, {31'b0, m_err}, "err");
            known = 1; ev = 0;
            if (c && !w) begin
                rg = region(a);
                if (rg == 0) begin
                    if (m_mem.exists(int'(a / 4))) ev = m_mem[int'(a / 4)];
                    else known = 0;
                end else if (rg == 1) begin
                    case (a - MB)
                        0:       ev = m_verify;
                        4:       ev = {31'b0, m_done};
                        8:       ev = m_cnt;
                        default: ev = {31'b0, m_err};
                    endcase
                end
            end
            if (known) push(0, ev, "data_o");
        end
        model_step(r, c, w, a, d);
    endtask

    task automatic chk(input int sel, input logic [31:0] v, input string name);
        push(sel, v, name);
    endtask

    // Monitor: compares every expectation tagged with the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() != 0 && q[0].cyc <= cyc_now) begin
                exp_t        e;
                logic [31:0] act;
                e = q.pop_front();
                case (e.sel)
                    0:       act = data_o;
                    1:       act = verify;
                    2:       act = {31'b0, done};
                    3:       act = cycle_cnt;
                    default: act = {31'b0, err};
                endcase
                n_chk++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s cyc=%0d got=%h want=%h", e.name, e.cyc, act, e.exp);
            end
        end
    end

    initial begin
        rst = 0; ce = 0; we = 0; addr = 0; data_i = 0;
        m_valid = 0; m_verify = 0; m_cnt = 0; m_done = 0; m_err = 0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk(3, 32'h0, "reset_cnt");
        chk(2, 32'h0, "reset_done");

        for (int i = 0; i < 17; i++) begin
            int unsigned idx;
            idx = (i == 16) ? DEPTH - 1 : i;
            step(1, 1, 1, idx * 4, $urandom);
        end

        // Basic write/read.
        step(1, 1, 1, 32'h10, 32'hDEAD_BEEF);
        step(1, 1, 0, 32'h10, 0);
        chk(0, 32'hDEAD_BEEF, "t1_read");
        chk(4, 32'h0, "t1_err");
        // Overwrite an existing value.
        step(1, 1, 1, 32'h20, 32'h1);
        step(1, 1, 0, 32'h20, 0);
        chk(0, 32'h1, "t2_old");
        step(1, 1, 1, 32'h20, 32'h5);
        chk(0, 32'h0, "t2_wr_dout");
        step(1, 1, 0, 32'h20, 0);
        chk(0, 32'h5, "t2_new");
        // VERIFY register.
        step(1, 1, 1, MB, 32'h2A);
        step(1, 1, 0, MB, 0);
        chk(1, 32'h2A, "t3_verify");
        chk(0, 32'h2A, "t3_read");
        // Cycle counter freezes on done.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 1, MB + 4, 32'h1);
        step(1, 0, 0, 0, 0);
        chk(2, 32'h1, "t4_done");
        chk(3, 32'd100, "t4_cnt");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 1, MB + 4, 32'h0);
        step(1, 1, 1, MB + 8, 32'h1234);
        step(1, 1, 0, MB + 8, 0);
        chk(0, 32'd100, "t4_cnt_read");
        chk(2, 32'h1, "t4_done_hold");
        chk(4, 32'h0, "t4_cycle_wr_noerr");
        // Errors and clear.
        step(1, 1, 1, 32'h0, 32'hABC);
        step(1, 1, 0, 32'h13, 0);
        chk(0, 32'h0, "t5_misaligned");
        step(1, 1, 1, 32'h9000, 32'h7);
        chk(4, 32'h1, "t5_err_set");
        step(1, 1, 0, 32'h0, 0);
        chk(0, 32'hABC, "t5_ram_kept");
        step(1, 1, 1, MB + 12, 32'h1);
        step(1, 1, 0, DEPTH * 4 - 4, 0);
        chk(4, 32'h0, "t5_err_clr");
        step(1, 1, 0, DEPTH * 4, 0);
        step(1, 1, 0, MB + 16, 0);
        chk(4, 32'h1, "t5_first_unmapped");
        // Reset drops a concurrent write.
        step(1, 1, 1, 32'h30, 32'h11);
        step(1, 1, 1, MB, 32'h2A);
        step(0, 1, 1, 32'h30, 32'h77);
        step(1, 1, 0, 32'h30, 0);
        chk(0, 32'h11, "t6_ram_kept");
        chk(1, 32'h0, "t6_verify");
        chk(2, 32'h0, "t6_done");
        chk(3, 32'h0, "t6_cnt");
        chk(4, 32'h0, "t6_err");

        for (int i = 0; i < 1500; i++) begin
            int unsigned k, j;
            logic [31:0] a, d;
            logic [31:0] bad_list [5];
            bad_list = '{DEPTH * 4, MB - 4, MB + 16, 32'h9000, 32'hFFFF_FFFC};
            k = $urandom_range(0, 99);
            j = $urandom_range(0, 16);
            a = ((j == 16) ? DEPTH - 1 : j) * 4;
            if (k >= 55 && k < 80) a = MB + 4 * $urandom_range(0, 3);
            else if (k >= 80 && k < 87) a = a + $urandom_range(1, 3);
            else if (k >= 87) a = bad_list[$urandom_range(0, 4)];
            d = $urandom;
            if (a == MB + 4) d = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, a, d);
        end

        step(1, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
